// File: rtl/clk_ratio_gen_pkg.sv
// clk_ratio_gen_pkg
//   Shared definitions for the ratio clock-enable generator.
//   - chan_state_t : per-channel sequencing states (IDLE -> PHASE -> RUN)
//   - lock_cnt_w() : width needed for a counter that reaches a given value
package clk_ratio_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_RUN   = 2'd2
  } chan_state_t;

  function automatic int lock_cnt_w(input int lock_cycles);
    return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_ratio_chan.sv
// clk_ratio_chan
//   One channel of the ratio generator. After start_i it waits PHASE enabled
//   cycles, then produces en_o pulses at density MUL/DIV using a modulo-DIV
//   accumulator. ck_o toggles on every pulse.
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   clear_i   synchronous return to the reset state (resync)
//   start_i   one-cycle pulse coinciding with the lock edge
//   run_en_i  channel enable; low freezes all channel state
//   en_o      registered one-cycle clock-enable pulse
//   ck_o      registered toggle clock, resets high
module clk_ratio_chan
  import clk_ratio_gen_pkg::*;
#(
  parameter int                 RATIO_W = 8,
  parameter logic [RATIO_W-1:0] MUL     = '0,
  parameter logic [RATIO_W-1:0] DIV     = RATIO_W'(1),
  parameter logic [RATIO_W-1:0] PHASE   = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic start_i,
  input  logic run_en_i,
  output logic en_o,
  output logic ck_o
);

  localparam logic [RATIO_W:0] DIV_X   = {1'b0, DIV};
  localparam logic [RATIO_W:0] PHASE_X = {1'b0, PHASE};
  // A zero divisor disables the channel; MUL above DIV saturates to one
  // pulse per cycle.
  localparam logic [RATIO_W:0] MUL_EFF = (DIV == '0)  ? '0 :
                                         (MUL >= DIV) ? DIV_X : {1'b0, MUL};
  localparam bit               ACTIVE  = (MUL_EFF != '0);

  if (DIV == '0) begin : g_div_zero
    $error("clk_ratio_chan: DIV must be non-zero; channel forced idle");
  end

  chan_state_t          state;
  logic [RATIO_W:0]     acc;
  logic [RATIO_W-1:0]   pcnt;
  logic [RATIO_W:0]     sum;
  logic [RATIO_W:0]     pcnt_next;

  // NOTE: every always_comb output gets a value on every path, otherwise a
  // latch is inferred; here the expressions are unconditional.
  always_comb begin
    sum       = acc + MUL_EFF;   // acc < DIV, so this never exceeds 2*DIV-1
    pcnt_next = {1'b0, pcnt} + (RATIO_W + 1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      acc   <= '0;
      pcnt  <= '0;
      en_o  <= 1'b0;
      ck_o  <= 1'b1;
    end else if (clear_i) begin
      state <= ST_IDLE;
      acc   <= '0;
      pcnt  <= '0;
      en_o  <= 1'b0;
      ck_o  <= 1'b1;
    end else begin
      en_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Zero phase skips PHASE so RUN coincides with the first locked cycle.
          if (start_i) state <= (PHASE == '0) ? ST_RUN : ST_PHASE;
        end
        ST_PHASE: begin
          if (run_en_i) begin
            pcnt <= pcnt_next[RATIO_W-1:0];
            if (pcnt_next == PHASE_X) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_en_i) begin
            if (ACTIVE && (sum >= DIV_X)) begin
              acc  <= sum - DIV_X;
              en_o <= 1'b1;
              ck_o <= ~ck_o;
            end else begin
              acc <= sum;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/clk_ratio_gen.sv
// clk_ratio_gen
//   Multi-channel rational clock-enable generator (PLL replacement). Each
//   channel emits en_o pulses at clk_i*MUL/DIV after a per-channel start
//   phase, plus a toggle clock ck_o. locked_o rises LOCK_CYCLES cycles after
//   reset release or resync. Packed vectors hold channel 0 in the LSBs; with
//   the defaults channels 0/1 run at 4/5 and channel 2 at 8/5 (clamped to 1).
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   resync_i   synchronous restart of lock counter and all channels
//   chan_en_i  per-channel run enable
//   locked_o   lock indicator
//   en_o       per-channel one-cycle enable pulses
//   ck_o       per-channel toggle clocks
module clk_ratio_gen
  import clk_ratio_gen_pkg::*;
#(
  parameter int                        NUM_CH      = 3,
  parameter int                        RATIO_W     = 8,
  parameter logic [NUM_CH*RATIO_W-1:0] MUL_VEC     = {8'd8, 8'd4, 8'd4},
  parameter logic [NUM_CH*RATIO_W-1:0] DIV_VEC     = {8'd5, 8'd5, 8'd5},
  parameter logic [NUM_CH*RATIO_W-1:0] PHASE_VEC   = {8'd0, 8'd0, 8'd0},
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              resync_i,
  input  logic [NUM_CH-1:0] chan_en_i,
  output logic              locked_o,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] ck_o
);

  localparam int             LCW       = lock_cnt_w(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  logic [LCW-1:0] lock_cnt;
  logic           start;

  // Fires on the edge that raises locked_o, so channels leave IDLE together
  // with the lock indicator. Resync wins over a coincident lock edge.
  assign start = !locked_o && !resync_i && (lock_cnt == LOCK_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_cnt <= '0;
      locked_o <= 1'b0;
    end else if (resync_i) begin
      lock_cnt <= '0;
      locked_o <= 1'b0;
    end else if (!locked_o) begin
      lock_cnt <= lock_cnt + LCW'(1);
      if (lock_cnt == LOCK_LAST) locked_o <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_ratio_chan #(
      .RATIO_W (RATIO_W),
      .MUL     (MUL_VEC  [i*RATIO_W +: RATIO_W]),
      .DIV     (DIV_VEC  [i*RATIO_W +: RATIO_W]),
      .PHASE   (PHASE_VEC[i*RATIO_W +: RATIO_W])
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (resync_i),
      .start_i  (start),
      .run_en_i (chan_en_i[i]),
      .en_o     (en_o[i]),
      .ck_o     (ck_o[i])
    );
  end

endmodule
